// File: rtl/repacker_pkg.sv
// rtl/repacker_pkg.sv - shared constants, width helpers and the in_cnt check macro for the frame repacker
//   IN_DEF/OUT_DEF/W_DEF : default words per input beat, words per output beat, bits per word
//   cnt_width(n)         : bits needed to hold a count 0..n
//   umin(a, b)           : unsigned minimum
//   REPACKER_CNT_CHECK   : assertion that a valid beat never carries more words than the bus holds

`define REPACKER_CNT_CHECK(clk, rstn, vld, cnt, max) \
    assert property (@(posedge clk) disable iff (!(rstn)) (vld) |-> (32'(cnt) <= (max)));

package repacker_pkg;

    localparam int unsigned IN_DEF  = 3;
    localparam int unsigned OUT_DEF = 8;
    localparam int unsigned W_DEF   = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/repacker_frame_if.sv
// rtl/repacker_frame_if.sv - input/output stream bundle of the frame repacker
//   in_val_i/in_data_i/in_cnt_i/in_last_i/in_rdy_o : narrow input beats, in_cnt_i valid low words
//   out_val_o/out_data_o/out_cnt_o/out_last_o/out_rdy_i : wide output beats, out_cnt_o valid low words
//   level_o : words currently stored
//   modport slave = repacker side, modport master = producer/consumer side

interface repacker_frame_if #(
    parameter int unsigned IN  = repacker_pkg::IN_DEF,
    parameter int unsigned OUT = repacker_pkg::OUT_DEF,
    parameter int unsigned W   = repacker_pkg::W_DEF
);
    localparam int unsigned BUFF = IN + OUT - 1;

    logic                                      in_val_i;
    logic [W*IN-1:0]                           in_data_i;
    logic [repacker_pkg::cnt_width(IN)-1:0]    in_cnt_i;
    logic                                      in_last_i;
    logic                                      in_rdy_o;
    logic                                      out_val_o;
    logic [W*OUT-1:0]                          out_data_o;
    logic [repacker_pkg::cnt_width(OUT)-1:0]   out_cnt_o;
    logic                                      out_last_o;
    logic                                      out_rdy_i;
    logic [repacker_pkg::cnt_width(BUFF)-1:0]  level_o;

    modport slave (
        input  in_val_i, in_data_i, in_cnt_i, in_last_i, out_rdy_i,
        output in_rdy_o, out_val_o, out_data_o, out_cnt_o, out_last_o, level_o
    );

    modport master (
        output in_val_i, in_data_i, in_cnt_i, in_last_i, out_rdy_i,
        input  in_rdy_o, out_val_o, out_data_o, out_cnt_o, out_last_o, level_o
    );
endinterface

// File: rtl/repacker_align.sv
// rtl/repacker_align.sv - next word store: shift out popped words, then place pushed words at base
//   mem      : current store, word i at [W*i +: W]
//   do_pop   : drop n_pop words from the bottom, zero-fill the top
//   do_push  : write data words 0..cnt-1 to store words base..base+cnt-1
//   mem_next : resulting store

module repacker_align #(
    parameter int unsigned IN   = 3,
    parameter int unsigned W    = 8,
    parameter int unsigned BUFF = 10,
    parameter int unsigned CW   = 4
) (
    input  logic [W*BUFF-1:0] mem,
    input  logic              do_pop,
    input  logic [CW-1:0]     n_pop,
    input  logic              do_push,
    input  logic [CW-1:0]     base,
    input  logic [CW-1:0]     cnt,
    input  logic [W*IN-1:0]   data,
    output logic [W*BUFF-1:0] mem_next
);

    always_comb begin
        mem_next = do_pop ? (mem >> (W * 32'(n_pop))) : mem;
        for (int unsigned i = 0; i < BUFF; i++) begin
            for (int unsigned j = 0; j < IN; j++) begin
                if (do_push && (CW'(j) < cnt) && (base + CW'(j) == CW'(i))) begin
                    mem_next[W*i +: W] = data[W*j +: W];
                end
            end
        end
    end

endmodule

// File: rtl/repacker_frame.sv
// rtl/repacker_frame.sv - framed IN-word to OUT-word stream width converter
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   srst_i : synchronous clear, overrides push/pop
//   bus    : repacker_frame_if.slave stream bundle (input beats, output beats, level_o)
//   Configuration macro: REPACKER_FLUSH_EN enables in_last_i frame flushing and out_last_o

module repacker_frame
    import repacker_pkg::*;
#(
    parameter int unsigned IN  = IN_DEF,
    parameter int unsigned OUT = OUT_DEF,
    parameter int unsigned W   = W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             srst_i,
    repacker_frame_if.slave  bus
);

    localparam int unsigned BUFF = IN + OUT - 1;
    localparam int unsigned CW   = $clog2(BUFF + IN + 1);
    localparam int unsigned OCW  = cnt_width(OUT);
    localparam int unsigned LW   = cnt_width(BUFF);
    localparam logic [CW-1:0] IN_C   = CW'(IN);
    localparam logic [CW-1:0] OUT_C  = CW'(OUT);
    localparam logic [CW-1:0] BUFF_C = CW'(BUFF);

    logic [CW-1:0]     v_q, v_d, v_post, n_pop, n_push, cnt_c;
    logic              f_q, f_d;
    logic              pop, push, out_val, out_last, in_rdy;
    logic [W*BUFF-1:0] mem_q, mem_d;
    logic [W*OUT-1:0]  out_data;

    always_comb begin
        n_pop = CW'(umin(32'(v_q), OUT));
`ifdef REPACKER_FLUSH_EN
        out_val  = (v_q >= OUT_C) || f_q;
        out_last = f_q && (v_q <= OUT_C);
`else
        out_val  = (v_q >= OUT_C);
        out_last = 1'b0;
`endif
        pop    = out_val && bus.out_rdy_i;
        // Space freed by a same-cycle pop is offered to the producer immediately.
        v_post = pop ? (v_q - n_pop) : v_q;
        in_rdy = !f_q && ((v_post + IN_C) <= BUFF_C);
        cnt_c  = CW'(umin(32'(bus.in_cnt_i), IN));
        push   = bus.in_val_i && in_rdy;
        n_push = push ? cnt_c : '0;
        v_d    = v_post + n_push;
`ifdef REPACKER_FLUSH_EN
        f_d = f_q;
        if (pop && out_last) begin
            f_d = 1'b0;
        end
        if (push && bus.in_last_i) begin
            f_d = 1'b1;
        end
`else
        f_d = 1'b0;
`endif
    end

`ifndef REPACKER_FLUSH_EN
    logic unused_last;
    assign unused_last = bus.in_last_i;
`endif

    repacker_align #(
        .IN   (IN),
        .W    (W),
        .BUFF (BUFF),
        .CW   (CW)
    ) u_align (
        .mem      (mem_q),
        .do_pop   (pop),
        .n_pop    (n_pop),
        .do_push  (push),
        .base     (v_post),
        .cnt      (cnt_c),
        .data     (bus.in_data_i),
        .mem_next (mem_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q   <= '0;
            f_q   <= 1'b0;
            mem_q <= '0;
        end else if (srst_i) begin
            v_q   <= '0;
            f_q   <= 1'b0;
            mem_q <= '0;
        end else begin
            v_q   <= v_d;
            f_q   <= f_d;
            mem_q <= mem_d;
        end
    end

    // Store words above v are already zero; the mask keeps unused output words clean regardless.
    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < OUT; k++) begin
            if (CW'(k) < n_pop) begin
                out_data[W*k +: W] = mem_q[W*k +: W];
            end
        end
    end

    assign bus.in_rdy_o   = in_rdy;
    assign bus.out_val_o  = out_val;
    assign bus.out_data_o = out_data;
    assign bus.out_cnt_o  = OCW'(n_pop);
    assign bus.out_last_o = out_last;
    assign bus.level_o    = LW'(v_q);

    `REPACKER_CNT_CHECK(clk_i, rst_ni, bus.in_val_i, bus.in_cnt_i, IN)

endmodule

// File: tb/tb_repacker_frame.sv
// tb/tb_repacker_frame.sv - self-checking bench for repacker_frame (IN=3, OUT=8, W=8)

module tb_repacker_frame;

    logic clk;
    logic rst_n;
    logic srst;

    repacker_frame_if #(.IN(3), .OUT(8), .W(8)) bus ();

    repacker_frame #(.IN(3), .OUT(8), .W(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .srst_i (srst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of stored words plus the pending-flush flag.
    int          mq[$];
    bit          mf;
    logic [7:0]  got[$];
    int          cnt_log[$];
    bit          last_log[$];
    int          n_beats  = 0;
    bit          saw_last = 0;
    bit          hold     = 0;
    logic [63:0] prev_data;
    logic [3:0]  prev_cnt;
    logic        prev_last;

    always @(negedge clk) begin
        int n, ecnt, c;
        bit eval, elast, erdy, mpop;
        logic [63:0] ed;
        if (!rst_n) begin
            mq.delete();
            mf = 0;
        end
        n    = mq.size();
        ecnt = (n < 8) ? n : 8;
`ifdef REPACKER_FLUSH_EN
        eval  = (n >= 8) || mf;
        elast = mf && (n <= 8);
`else
        eval  = (n >= 8);
        elast = 0;
`endif
        ed = '0;
        for (int k = 0; k < ecnt; k++) ed[8*k +: 8] = mq[k][7:0];
        mpop = eval && bus.out_rdy_i;
        erdy = !mf && ((n - (mpop ? ecnt : 0)) + 3 <= 10);
        chk("out_val", bus.out_val_o, eval);
        chk("out_cnt", bus.out_cnt_o, ecnt);
        chk("out_data", bus.out_data_o, ed);
        chk("out_last", bus.out_last_o, elast);
        chk("level", bus.level_o, n);
        chk("in_rdy", bus.in_rdy_o, erdy);
        if (hold) begin
            chk("hold_data", bus.out_data_o, prev_data);
            chk("hold_cnt", bus.out_cnt_o, prev_cnt);
            chk("hold_last", bus.out_last_o, prev_last);
        end
        if (bus.out_last_o === 1'b1) saw_last = 1;
        hold      = rst_n && !srst && bus.out_val_o && !bus.out_rdy_i;
        prev_data = bus.out_data_o;
        prev_cnt  = bus.out_cnt_o;
        prev_last = bus.out_last_o;
        if (rst_n && srst) begin
            mq.delete();
            mf = 0;
        end else if (rst_n) begin
            if (bus.out_val_o && bus.out_rdy_i) begin
                n_beats++;
                cnt_log.push_back(int'(bus.out_cnt_o));
                last_log.push_back(bus.out_last_o);
                for (int k = 0; k < int'(bus.out_cnt_o) && k < 8; k++) got.push_back(bus.out_data_o[8*k +: 8]);
            end
            if (mpop) begin
                repeat (ecnt) void'(mq.pop_front());
                if (elast) mf = 0;
            end
            if (bus.in_val_i && erdy) begin
                c = (int'(bus.in_cnt_i) < 3) ? int'(bus.in_cnt_i) : 3;
                for (int j = 0; j < c; j++) mq.push_back(int'(bus.in_data_i[8*j +: 8]));
`ifdef REPACKER_FLUSH_EN
                if (bus.in_last_i) mf = 1;
`endif
            end
        end
    end

    int nxt = 0;

    // Words are a running sequence; unused high words carry 8'hEE and must be ignored.
    task automatic set_beat(input int cnt, input bit last);
        logic [23:0] d;
        for (int j = 0; j < 3; j++) d[8*j +: 8] = (j < cnt) ? 8'(nxt + j) : 8'hEE;
        bus.in_data_i = d;
        bus.in_cnt_i  = 2'(cnt);
        bus.in_last_i = last;
    endtask

    task automatic push_beat(input int cnt, input bit last);
        int t;
        set_beat(cnt, last);
        bus.in_val_i = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_rdy_o && t < 200);
        if (!bus.in_rdy_o) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_val_i = 1'b0;
        nxt += cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, g0, s0, err;
        clk = 0;
        rst_n = 0;
        srst = 0;
        bus.out_rdy_i = 1'b1;
        set_beat(3, 0);
        bus.in_val_i = 1'b1;

        // Reset with a pending push
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", bus.in_rdy_o, 1);
        chk("rst_out_val", bus.out_val_o, 0);
        chk("rst_level", bus.level_o, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rel_in_rdy", bus.in_rdy_o, 1);
        @(posedge clk);
        #1;
        bus.in_val_i = 1'b0;
        nxt = 3;
        chk("rel_level", bus.level_o, 3);

        // Eight full beats, words 0..23
        repeat (7) push_beat(3, 0);
        idle(4);
        chk("s2_words", got.size(), 24);
        err = 0;
        for (int i = 0; i < 24 && i < got.size(); i++) if (got[i] !== 8'(i)) err++;
        chk("s2_order", err, 0);
        chk("s2_beats", n_beats, 3);
        chk("s2_level", bus.level_o, 0);

        // Ten-word frame
        b0 = n_beats;
        push_beat(3, 0);
        push_beat(3, 0);
        push_beat(3, 0);
        push_beat(1, 1);
        idle(4);
`ifdef REPACKER_FLUSH_EN
        chk("s3_beats", n_beats - b0, 2);
        chk("s3_cnt0", cnt_log[b0], 8);
        chk("s3_last0", last_log[b0], 0);
        chk("s3_cnt1", cnt_log[b0+1], 2);
        chk("s3_last1", last_log[b0+1], 1);
        chk("s3_level", bus.level_o, 0);
`else
        chk("s7_beats", n_beats - b0, 1);
        chk("s7_cnt0", cnt_log[b0], 8);
        chk("s7_level", bus.level_o, 2);
        chk("s7_no_last", saw_last, 0);
`endif

        // Synchronous clear
        srst = 1;
        idle(1);
        srst = 0;
        chk("s6a_level", bus.level_o, 0);
        bus.out_rdy_i = 1'b0;
        push_beat(3, 0);
        push_beat(2, 1);
        chk("s6_pre_level", bus.level_o, 5);
        set_beat(3, 0);
        bus.in_val_i = 1'b1;
        srst = 1;
        idle(1);
        srst = 0;
        bus.in_val_i = 1'b0;
        chk("s6_level", bus.level_o, 0);
        chk("s6_out_val", bus.out_val_o, 0);
        chk("s6_in_rdy", bus.in_rdy_o, 1);

        // Backpressure mid-stream
        s0 = nxt;
        g0 = got.size();
        push_beat(3, 0);
        push_beat(3, 0);
        push_beat(3, 0);
        fork
            push_beat(3, 0);
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("bp_level", bus.level_o, 9);
                chk("bp_in_rdy", bus.in_rdy_o, 0);
                bus.out_rdy_i = 1'b1;
            end
        join
        push_beat(2, 0);
        push_beat(0, 0);
        push_beat(1, 0);
        push_beat(3, 0);
        push_beat(2, 0);
        idle(4);
        chk("bp_popped", got.size() - g0, 16);
        err = 0;
        for (int i = 0; i < 16 && g0 + i < got.size(); i++) if (got[g0+i] !== 8'(s0 + i)) err++;
        chk("bp_order", err, 0);
        chk("bp_level_end", bus.level_o, 4);

`ifdef REPACKER_FLUSH_EN
        // Close the pending frame with an empty last beat
        b0 = n_beats;
        push_beat(0, 1);
        idle(3);
        chk("tail_cnt", cnt_log[b0], 4);
        chk("tail_last", last_log[b0], 1);
        chk("tail_level", bus.level_o, 0);

        // Empty frame
        bus.out_rdy_i = 1'b0;
        push_beat(0, 1);
        @(negedge clk);
        chk("s5_out_val", bus.out_val_o, 1);
        chk("s5_out_cnt", bus.out_cnt_o, 0);
        chk("s5_out_last", bus.out_last_o, 1);
        chk("s5_in_rdy", bus.in_rdy_o, 0);
        @(posedge clk);
        #1 bus.out_rdy_i = 1'b1;
        idle(1);
        chk("s5_after_val", bus.out_val_o, 0);
        chk("s5_after_rdy", bus.in_rdy_o, 1);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
